// File: rtl/rede_out_collector.sv
// Purpose: collect result words from NCORES rede cores into one tagged FIFO stream via round-robin.
// Latency: 2 cycles from out_en to m_valid (capture edge, then grant/push edge); 1 word/cycle sustained.
// Backpressure: m_ready low holds the head; a full FIFO parks words per core; a re-fire onto a parked word drops the new word and flags overflow.
module rede_out_collector #(
    parameter int NCORES = 21,
    parameter int DW     = 31,
    parameter int EW     = 4,
    parameter int IDW    = 5,
    parameter int DEPTH  = 16,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES*DW-1:0]     io_out,
    input  logic [NCORES*EW-1:0]     out_en,
    output logic signed [DW-1:0]     m_data,
    output logic [IDW-1:0]           m_core,
    output logic [EW-1:0]            m_tag,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CW-1:0]            count,
    output logic                     overflow,
    output logic [IDW-1:0]           lost_core
);

    typedef struct packed {
        logic signed [DW-1:0] data;
        logic [IDW-1:0]       core;
        logic [EW-1:0]        tag;
    } entry_t;

    // Per-core holding registers
    logic [NCORES-1:0]    pend_q, pend_d;
    logic signed [DW-1:0] pend_data_q [NCORES];
    logic signed [DW-1:0] pend_data_d [NCORES];
    logic [EW-1:0]        pend_tag_q  [NCORES];
    logic [EW-1:0]        pend_tag_d  [NCORES];

    // Arbiter and error tracking
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                 overflow_q, overflow_d;
    logic [IDW-1:0]       lost_core_q, lost_core_d;

    // FIFO storage and pointers
    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 gnt_found;
    logic [IDW-1:0]       gnt_idx;
    logic                 grant_vld;
    logic                 pop;
    logic                 can_write;
    entry_t               head;

    // Round-robin search: first pending core at or after rr_ptr, wrapping at NCORES-1
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NCORES; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NCORES)) begin
                sum = sum - (IDW+1)'(NCORES);
            end
            idx = sum[IDW-1:0];
            if (!gnt_found && pend_q[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // A grant needs FIFO room; a same-cycle pop frees the slot even when full
    always_comb begin
        pop       = (count_q != '0) && m_ready;
        can_write = (count_q < CW'(DEPTH)) || pop;
        grant_vld = gnt_found && can_write;
        rr_ptr_d  = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (gnt_idx == IDW'(NCORES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Capture new words, retire granted ones, and record the lowest-index drop
    always_comb begin
        logic           cap;
        logic           gk;
        logic           drop_found;
        logic [IDW-1:0] drop_idx;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_tag_d  = pend_tag_q;
        overflow_d  = overflow_q;
        lost_core_d = lost_core_q;
        drop_found  = 1'b0;
        drop_idx    = '0;
        cap         = 1'b0;
        gk          = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            cap = |out_en[k*EW +: EW];
            gk  = grant_vld && (gnt_idx == IDW'(k));
            if (cap) begin
                if (pend_q[k] && !gk) begin
                    // Older word still parked: keep it, discard the newcomer
                    if (!drop_found) begin
                        drop_found = 1'b1;
                        drop_idx   = IDW'(k);
                    end
                end else begin
                    pend_d[k]      = 1'b1;
                    pend_data_d[k] = io_out[k*DW +: DW];
                    pend_tag_d[k]  = out_en[k*EW +: EW];
                end
            end else if (gk) begin
                pend_d[k] = 1'b0;
            end
        end
        if (drop_found) begin
            overflow_d = 1'b1;
            if (!overflow_q) begin
                lost_core_d = drop_idx;
            end
        end
    end

    // FIFO write, pointer advance and occupancy update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (grant_vld) begin
            mem_d[wr_ptr_q] = '{data: pend_data_q[gnt_idx], core: gnt_idx, tag: pend_tag_q[gnt_idx]};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({grant_vld, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; discards all parked and queued words
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            lost_core_q <= '0;
        end else begin
            pend_q      <= pend_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            lost_core_q <= lost_core_d;
        end
    end

    // Data payloads are only meaningful under their valid/pending bits, so they carry no reset
    always_ff @(posedge clk) begin
        pend_data_q <= pend_data_d;
        pend_tag_q  <= pend_tag_d;
        mem_q       <= mem_d;
    end

    // Head is zeroed while empty so stale entries never leak out
    always_comb begin
        head      = mem_q[rd_ptr_q];
        m_valid   = (count_q != '0);
        m_data    = m_valid ? head.data : '0;
        m_core    = m_valid ? head.core : '0;
        m_tag     = m_valid ? head.tag  : '0;
        count     = count_q;
        overflow  = overflow_q;
        lost_core = lost_core_q;
    end

endmodule

// File: tb/tb_rede_out_collector.sv
// Directed bench for rede_out_collector: latency, round-robin order, back-pressure, drop and reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected values are hand-derived from the cycle-level behaviour of the collector.
module tb_rede_out_collector;

    localparam int NCORES = 21;
    localparam int DW     = 31;
    localparam int EW     = 4;
    localparam int IDW    = 5;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst;
    logic [NCORES*DW-1:0]   io_out;
    logic [NCORES*EW-1:0]   out_en;
    logic signed [DW-1:0]   m_data;
    logic [IDW-1:0]         m_core;
    logic [EW-1:0]          m_tag;
    logic                   m_valid;
    logic                   m_ready;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic [IDW-1:0]         lost_core;

    int checks;
    int errors;

    rede_out_collector #(
        .NCORES(NCORES), .DW(DW), .EW(EW), .IDW(IDW), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io_out    (io_out),
        .out_en    (out_en),
        .m_data    (m_data),
        .m_core    (m_core),
        .m_tag     (m_tag),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count),
        .overflow  (overflow),
        .lost_core (lost_core)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", nm, obs, exp);
        end
    endtask

    task automatic expect_head(input string nm, input int core,
                               input logic signed [DW-1:0] d, input logic [EW-1:0] t);
        chk({nm, ".valid"}, 32'(m_valid), 32'd1);
        chk({nm, ".core"},  32'(m_core),  32'(core));
        chk({nm, ".tag"},   32'(m_tag),   32'(t));
        checks++;
        assert (m_data === d) else begin
            errors++;
            $error("FAIL %s.data: got %0d expected %0d", nm, m_data, d);
        end
    endtask

    task automatic set_core(input int k, input logic signed [DW-1:0] d, input logic [EW-1:0] t);
        io_out[k*DW +: DW] = d;
        out_en[k*EW +: EW] = t;
    endtask

    task automatic clear_in();
        io_out = '0;
        out_en = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        m_ready = 1'b0;
        clear_in();
        tick();
        tick();

        // Reset state
        chk("rst.valid",     32'(m_valid),   32'd0);
        chk("rst.count",     32'(count),     32'd0);
        chk("rst.overflow",  32'(overflow),  32'd0);
        chk("rst.lost_core", 32'(lost_core), 32'd0);
        chk("rst.data",      32'(m_data),    32'd0);
        chk("rst.core",      32'(m_core),    32'd0);
        chk("rst.tag",       32'(m_tag),     32'd0);

        // Simultaneous burst from cores 0, 7, 20 with rr_ptr = 0
        rst     = 1'b0;
        m_ready = 1'b1;
        set_core(0, 10, 4'd2);
        set_core(7, 70, 4'd3);
        set_core(20, 200, 4'd4);
        tick();
        clear_in();
        chk("burst.t1_valid", 32'(m_valid), 32'd0);
        tick();
        expect_head("burst0", 0, 10, 4'd2);
        chk("burst0.count", 32'(count), 32'd1);
        tick();
        expect_head("burst1", 7, 70, 4'd3);
        tick();
        expect_head("burst2", 20, 200, 4'd4);
        tick();
        chk("burst.empty", 32'(m_valid), 32'd0);
        chk("burst.count", 32'(count), 32'd0);

        // rr_ptr wrapped to 0: core 0 must beat core 20
        set_core(20, 6, 4'd5);
        set_core(0, 5, 4'd6);
        tick();
        clear_in();
        tick();
        expect_head("wrap0", 0, 5, 4'd6);
        tick();
        expect_head("wrap1", 20, 6, 4'd5);
        tick();
        chk("wrap.empty", 32'(m_valid), 32'd0);

        // Single word: valid for exactly one cycle, two cycles after out_en
        set_core(3, -5, 4'd1);
        tick();
        clear_in();
        chk("single.t1_valid", 32'(m_valid), 32'd0);
        tick();
        expect_head("single", 3, -5, 4'd1);
        chk("single.overflow", 32'(overflow), 32'd0);
        tick();
        chk("single.t3_valid", 32'(m_valid), 32'd0);

        // Reset to bring rr_ptr back to 0
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        m_ready = 1'b0;

        // Back-pressure: fill with cores 0..15, then core 16 waits pending
        for (int k = 0; k < 16; k++) set_core(k, 100 + k, 4'd1);
        tick();
        clear_in();
        repeat (16) tick();
        chk("bp.full_count", 32'(count), 32'd16);
        expect_head("bp.head", 0, 100, 4'd1);
        set_core(16, 116, 4'd3);
        tick();
        clear_in();
        tick();
        chk("bp.hold_count", 32'(count), 32'd16);
        expect_head("bp.hold", 0, 100, 4'd1);

        // Full push/pop: count stays 16, head advances one entry
        m_ready = 1'b1;
        tick();
        chk("fullpp.count", 32'(count), 32'd16);
        expect_head("fullpp", 1, 101, 4'd1);
        for (int k = 2; k <= 16; k++) begin
            tick();
            expect_head($sformatf("bp%0d", k), k, 100 + k, (k == 16) ? 4'd3 : 4'd1);
        end
        tick();
        chk("bp.empty",    32'(m_valid),  32'd0);
        chk("bp.count",    32'(count),    32'd0);
        chk("bp.overflow", 32'(overflow), 32'd0);

        // Drop: FIFO full, core 5 fires twice three cycles apart
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) set_core(k, 100 + k, 4'd1);
        tick();
        clear_in();
        repeat (16) tick();
        chk("drop.full_count", 32'(count), 32'd16);
        set_core(5, 1, 4'd1);
        tick();
        clear_in();
        chk("drop.first_ok", 32'(overflow), 32'd0);
        tick();
        tick();
        set_core(5, 2, 4'd1);
        tick();
        clear_in();
        chk("drop.overflow",  32'(overflow),  32'd1);
        chk("drop.lost_core", 32'(lost_core), 32'd5);
        m_ready = 1'b1;
        expect_head("drop0", 0, 100, 4'd1);
        for (int k = 1; k < 16; k++) begin
            tick();
            expect_head($sformatf("drop%0d", k), k, 100 + k, 4'd1);
        end
        tick();
        expect_head("drop.c5", 5, 1, 4'd1);
        tick();
        chk("drop.empty",  32'(m_valid),  32'd0);
        chk("drop.sticky", 32'(overflow), 32'd1);

        // Reset mid-operation: 9 queued, 3 pending
        m_ready = 1'b0;
        for (int k = 0; k < 12; k++) set_core(k, 200 + k, 4'd2);
        tick();
        clear_in();
        repeat (9) tick();
        chk("mid.count9", 32'(count), 32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.valid",     32'(m_valid),   32'd0);
        chk("mid.count",     32'(count),     32'd0);
        chk("mid.overflow",  32'(overflow),  32'd0);
        chk("mid.lost_core", 32'(lost_core), 32'd0);
        repeat (3) tick();
        chk("mid.no_pending_count", 32'(count),   32'd0);
        chk("mid.no_pending_valid", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        set_core(2, -7, 4'd15);
        tick();
        clear_in();
        chk("post.t1_valid", 32'(m_valid), 32'd0);
        tick();
        expect_head("post", 2, -7, 4'd15);
        tick();
        chk("post.empty", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
